cvxif_mac4b_master: RTL and testbench

CVXIF_MAC4B_MASTER -- requirements
Module: cvxif_mac4b_master

---
 rtl/cvxif_mac4b_master_pkg.sv | 17 +
 rtl/cvxif_pkg.sv | 50 +++++
 rtl/cvxif_mac4b_watchdog.sv | 37 +++
 rtl/cvxif_mac4b_master.sv | 176 +++++++++++++++++
 tb/tb_cvxif_mac4b_master.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvxif_mac4b_master_pkg.sv
// Shared FSM encoding, MAC4B opcode match/mask and default watchdog depth.
package cvxif_mac4b_master_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMMIT   = 2'd2,
        WAIT_RES = 2'd3
    } state_e;

    // custom-1 major opcode, funct3 = 0, funct7 = 0
    localparam logic [31:0] MAC4B_MATCH = 32'h0000_002B;
    localparam logic [31:0] MAC4B_MASK  = 32'hFE00_707F;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/cvxif_pkg.sv
// CV-X-IF subset used by the MAC4B master: issue, commit and result channels.
package cvxif_pkg;

    localparam int X_NUM_RS    = 2;
    localparam int X_RFR_WIDTH = 32;
    localparam int X_RFW_WIDTH = 32;
    localparam int X_ID_WIDTH  = 4;

    typedef logic [X_ID_WIDTH-1:0] x_id_t;

    typedef struct packed {
        logic [31:0]                            instr;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]   rs;
        logic [X_NUM_RS-1:0]                    rs_valid;
        x_id_t                                  id;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
    } x_issue_resp_t;

    typedef struct packed {
        x_id_t id;
        logic  commit_kill;
    } x_commit_t;

    typedef struct packed {
        x_id_t                  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
    } x_result_t;

    typedef struct packed {
        logic         x_issue_valid;
        x_issue_req_t x_issue_req;
        logic         x_commit_valid;
        x_commit_t    x_commit;
        logic         x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic          x_issue_ready;
        x_issue_resp_t x_issue_resp;
        logic          x_result_valid;
        x_result_t     x_result;
    } cvxif_resp_t;

endpackage

// File: rtl/cvxif_mac4b_watchdog.sv
// Counts consecutive run_i cycles; expired_o fires combinationally in the Cycles-th one.
// Latency: expiry visible in the same cycle as the last counted cycle.
// Backpressure: none; clear_i (or expiry) returns the count to zero.
module cvxif_mac4b_watchdog #(
    parameter int unsigned Cycles = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = run_i && (cnt_q == CntW'(Cycles - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cvxif_mac4b_master.sv
// Single-outstanding CV-X-IF master for MAC4B: issue -> commit -> wait result -> writeback.
// Latency: request to wb_valid_o >= 4 cycles; result watchdog enabled by CVXIF_MAC4B_TIMEOUT_EN.
// Backpressure: req_ready_o only in IDLE; issue fields held until x_issue_ready.
module cvxif_mac4b_master
    import cvxif_pkg::*;
    import cvxif_mac4b_master_pkg::*;
#(
    parameter int unsigned           TimeoutCycles = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [X_ID_WIDTH-1:0] IdInit        = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [31:0]                          instr_i,
    input  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_i,
    input  logic                                 kill_i,
    output cvxif_pkg::cvxif_req_t                cvxif_req_o,
    input  cvxif_pkg::cvxif_resp_t               cvxif_resp_i,
    output logic                                 wb_valid_o,
    output logic [4:0]                           wb_rd_o,
    output logic [X_RFW_WIDTH-1:0]               wb_data_o,
    output logic                                 illegal_o,
    output logic                                 timeout_o
);

    state_e                               state_q, state_d;
    logic [X_ID_WIDTH-1:0]                id_cnt_q, id_cnt_d, id_q, id_d;
    logic [31:0]                          instr_q, instr_d;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_q, rs_d;
    logic                                 wb_en_q, wb_en_d;
    logic                                 req_ready_q, req_ready_d;
    logic                                 issue_valid_q, issue_valid_d;
    logic                                 commit_valid_q, commit_valid_d;
    logic                                 result_ready_q, result_ready_d;
    logic                                 wb_valid_q, wb_valid_d;
    logic                                 illegal_q, illegal_d;
    logic                                 timeout_q, timeout_d;
    logic [4:0]                           wb_rd_q, wb_rd_d;
    logic [X_RFW_WIDTH-1:0]               wb_data_q, wb_data_d;
    logic                                 wd_expired;
    logic                                 result_hit;

    // Results for another id or without a register write are consumed and dropped.
    assign result_hit = cvxif_resp_i.x_result_valid && cvxif_resp_i.x_result.we &&
                        (cvxif_resp_i.x_result.id == id_q);

`ifdef CVXIF_MAC4B_TIMEOUT_EN
    cvxif_mac4b_watchdog #(
        .Cycles(TimeoutCycles)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q != WAIT_RES),
        .run_i    (state_q == WAIT_RES),
        .expired_o(wd_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign wd_expired         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        id_cnt_d  = id_cnt_q;
        id_d      = id_q;
        instr_d   = instr_q;
        rs_d      = rs_q;
        wb_en_d   = wb_en_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_valid_d = 1'b0;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    instr_d = instr_i;
                    rs_d    = rs_i;
                    id_d    = id_cnt_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cvxif_resp_i.x_issue_ready) begin
                    id_cnt_d = id_cnt_q + X_ID_WIDTH'(1);
                    wb_en_d  = cvxif_resp_i.x_issue_resp.writeback;
                    if (cvxif_resp_i.x_issue_resp.accept) begin
                        state_d = COMMIT;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_d = (kill_i || !wb_en_q) ? IDLE : WAIT_RES;
            end
            WAIT_RES: begin
                if (result_hit) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = cvxif_resp_i.x_result.rd;
                    wb_data_d  = cvxif_resp_i.x_result.data;
                    state_d    = IDLE;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state so reset forces them low.
        req_ready_d    = (state_d == IDLE);
        issue_valid_d  = (state_d == ISSUE);
        commit_valid_d = (state_d == COMMIT);
        result_ready_d = (state_d == WAIT_RES);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            id_cnt_q       <= IdInit;
            id_q           <= '0;
            instr_q        <= '0;
            rs_q           <= '0;
            wb_en_q        <= 1'b0;
            req_ready_q    <= 1'b0;
            issue_valid_q  <= 1'b0;
            commit_valid_q <= 1'b0;
            result_ready_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            illegal_q      <= 1'b0;
            timeout_q      <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            id_cnt_q       <= id_cnt_d;
            id_q           <= id_d;
            instr_q        <= instr_d;
            rs_q           <= rs_d;
            wb_en_q        <= wb_en_d;
            req_ready_q    <= req_ready_d;
            issue_valid_q  <= issue_valid_d;
            commit_valid_q <= commit_valid_d;
            result_ready_q <= result_ready_d;
            wb_valid_q     <= wb_valid_d;
            illegal_q      <= illegal_d;
            timeout_q      <= timeout_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
        end
    end

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.x_issue_valid        = issue_valid_q;
        cvxif_req_o.x_issue_req.instr    = instr_q;
        cvxif_req_o.x_issue_req.rs       = rs_q;
        cvxif_req_o.x_issue_req.rs_valid = {X_NUM_RS{issue_valid_q}};
        cvxif_req_o.x_issue_req.id       = id_q;
        cvxif_req_o.x_commit_valid       = commit_valid_q;
        cvxif_req_o.x_commit.id          = id_q;
        cvxif_req_o.x_commit.commit_kill = commit_valid_q && kill_i;
        cvxif_req_o.x_result_ready       = result_ready_q;
    end

    assign req_ready_o = req_ready_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign illegal_o   = illegal_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cvxif_mac4b_master.sv
// Randomized scoreboard bench for cvxif_mac4b_master with an in-bench MAC4B coprocessor model.
module tb_cvxif_mac4b_master;
    import cvxif_pkg::*;
    import cvxif_mac4b_master_pkg::*;

    localparam logic [X_ID_WIDTH-1:0] ID_INIT = 4'hD;
    localparam int KIND_WB  = 0;
    localparam int KIND_ILL = 1;
    localparam int KIND_TO  = 2;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic                                 clk = 1'b0;
    logic                                 rst_n;
    logic                                 req_valid;
    logic                                 req_ready;
    logic [31:0]                          instr;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic                                 kill;
    cvxif_req_t                           creq;
    cvxif_resp_t                          cresp;
    logic                                 wb_valid;
    logic [4:0]                           wb_rd;
    logic [X_RFW_WIDTH-1:0]               wb_data;
    logic                                 illegal;
    logic                                 timeout;

    exp_t                  exp_q[$];
    exp_t                  mon_e;
    int                    compared   = 0;
    int                    mismatched = 0;
    logic [X_ID_WIDTH-1:0] id_model;
    logic [4:0]            last_rd;
    logic [31:0]           last_data;

    always #5 clk = ~clk;

    cvxif_mac4b_master #(
        .TimeoutCycles(8),
        .IdInit       (ID_INIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .instr_i     (instr),
        .rs_i        (rs),
        .kill_i      (kill),
        .cvxif_req_o (creq),
        .cvxif_resp_i(cresp),
        .wb_valid_o  (wb_valid),
        .wb_rd_o     (wb_rd),
        .wb_data_o   (wb_data),
        .illegal_o   (illegal),
        .timeout_o   (timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dot product of the four unsigned byte lanes.
    function automatic logic [31:0] mac4b(input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
        return 32'(s);
    endfunction

    task automatic push_exp(input int kind, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rd   = '0;
            last_data = '0;
        end else begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_wb: actual rd=%0d data=0x%0h required no writeback", wb_rd, wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_kind", 64'(KIND_WB), 64'(mon_e.kind));
                    check("wb_rd", 64'(wb_rd), 64'(mon_e.rd));
                    check("wb_data", 64'(wb_data), 64'(mon_e.data));
                    last_rd   = mon_e.rd;
                    last_data = mon_e.data;
                end
            end else begin
                check("wb_rd_hold", 64'(wb_rd), 64'(last_rd));
                check("wb_data_hold", 64'(wb_data), 64'(last_data));
            end
            if (illegal || timeout) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_pulse: actual illegal=%0b timeout=%0b required none", illegal, timeout);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", illegal ? 64'(KIND_ILL) : 64'(KIND_TO), 64'(mon_e.kind));
                end
            end
        end
    end

    task automatic run_txn(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                           input bit acc, input bit wbk, input bit kil, input int bp,
                           input int stale, input int res_delay, input bit noresult, input bit rst_mid);
        logic [31:0]                          ins;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rsv;
        logic [X_ID_WIDTH-1:0]                eid;
        int                                   n;
        ins        = MAC4B_MATCH;
        ins[11:7]  = rd;
        ins[19:15] = 5'($urandom);
        ins[24:20] = 5'($urandom);
        rsv[0]     = a;
        rsv[1]     = b;
        if (!acc) begin
            push_exp(KIND_ILL, '0, '0);
        end else if (!kil && wbk && !rst_mid) begin
`ifdef CVXIF_MAC4B_TIMEOUT_EN
            if (noresult) push_exp(KIND_TO, '0, '0);
            else          push_exp(KIND_WB, rd, mac4b(a, b));
`else
            push_exp(KIND_WB, rd, mac4b(a, b));
`endif
        end
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        if (!req_ready) return;
        req_valid = 1'b1;
        instr     = ins;
        rs        = rsv;
        kill      = 1'($urandom);
        tick();
        req_valid = 1'b0;
        instr     = $urandom;
        rs        = {32'($urandom), 32'($urandom)};
        eid       = id_model;
        check("issue_valid", 64'(creq.x_issue_valid), 64'd1);
        check("req_ready_busy", 64'(req_ready), 64'd0);
        for (int i = 0; i < bp; i++) begin
            check("bp_instr", 64'(creq.x_issue_req.instr), 64'(ins));
            check("bp_rs", 64'(creq.x_issue_req.rs), 64'(rsv));
            check("bp_id", 64'(creq.x_issue_req.id), 64'(eid));
            check("bp_valid", 64'(creq.x_issue_valid), 64'd1);
            tick();
        end
        cresp.x_issue_ready            = 1'b1;
        cresp.x_issue_resp.accept      = acc;
        cresp.x_issue_resp.writeback   = wbk;
        check("issue_instr", 64'(creq.x_issue_req.instr), 64'(ins));
        check("issue_rs", 64'(creq.x_issue_req.rs), 64'(rsv));
        check("issue_rs_valid", 64'(creq.x_issue_req.rs_valid), 64'({X_NUM_RS{1'b1}}));
        check("issue_id", 64'(creq.x_issue_req.id), 64'(eid));
        tick();
        cresp.x_issue_ready = 1'b0;
        id_model = id_model + 1'b1;
        if (!acc) begin
            check("rej_no_commit", 64'(creq.x_commit_valid), 64'd0);
            check("rej_req_ready", 64'(req_ready), 64'd1);
            tick();
            check("sb_drain", 64'(exp_q.size()), 64'd0);
            return;
        end
        kill = kil;
        #1;
        check("commit_valid", 64'(creq.x_commit_valid), 64'd1);
        check("commit_id", 64'(creq.x_commit.id), 64'(eid));
        check("commit_kill", 64'(creq.x_commit.commit_kill), 64'(kil));
        tick();
        kill = 1'($urandom);
        check("commit_one_cycle", 64'(creq.x_commit_valid), 64'd0);
        if (kil || !wbk) begin
            check("nowb_result_ready", 64'(creq.x_result_ready), 64'd0);
            check("nowb_req_ready", 64'(req_ready), 64'd1);
            tick();
            check("sb_drain", 64'(exp_q.size()), 64'd0);
            return;
        end
        check("wait_result_ready", 64'(creq.x_result_ready), 64'd1);
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_cvxif_req", 64'(|creq), 64'd0);
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_wb_valid", 64'(wb_valid), 64'd0);
            check("rst_wb_rd", 64'(wb_rd), 64'd0);
            check("rst_wb_data", 64'(wb_data), 64'd0);
            check("rst_pulses", 64'({illegal, timeout}), 64'd0);
            id_model = ID_INIT;
            exp_q.delete();
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            cresp.x_result_valid = 1'b1;
            cresp.x_result.id    = eid;
            cresp.x_result.we    = 1'b1;
            cresp.x_result.rd    = rd;
            cresp.x_result.data  = mac4b(a, b);
            for (int i = 0; i < 3; i++) begin
                tick();
                check("late_no_wb", 64'(wb_valid), 64'd0);
            end
            cresp.x_result_valid = 1'b0;
            check("sb_drain", 64'(exp_q.size()), 64'd0);
            return;
        end
        if (noresult) begin
`ifdef CVXIF_MAC4B_TIMEOUT_EN
            repeat (7) tick();
            check("to_not_early", 64'(timeout), 64'd0);
            check("to_still_waiting", 64'(creq.x_result_ready), 64'd1);
            tick();
            check("to_fired", 64'(timeout), 64'd1);
            check("to_left_wait", 64'(creq.x_result_ready), 64'd0);
            check("to_req_ready", 64'(req_ready), 64'd1);
            tick();
            check("sb_drain", 64'(exp_q.size()), 64'd0);
            return;
`else
            repeat (30) tick();
            check("nto_still_waiting", 64'(creq.x_result_ready), 64'd1);
            check("nto_no_pulse", 64'(timeout), 64'd0);
`endif
        end
        for (int i = 0; i < stale; i++) begin
            cresp.x_result_valid = 1'b1;
            cresp.x_result.id    = (i % 2 == 1) ? eid : eid + 1'b1;
            cresp.x_result.we    = (i % 2 == 1) ? 1'b0 : 1'b1;
            cresp.x_result.rd    = 5'($urandom);
            cresp.x_result.data  = $urandom;
            tick();
            cresp.x_result_valid = 1'b0;
            check("stale_no_wb", 64'(wb_valid), 64'd0);
            check("stale_keeps_wait", 64'(creq.x_result_ready), 64'd1);
        end
        repeat (res_delay) tick();
        cresp.x_result_valid = 1'b1;
        cresp.x_result.id    = eid;
        cresp.x_result.we    = 1'b1;
        cresp.x_result.rd    = rd;
        cresp.x_result.data  = mac4b(a, b);
        tick();
        cresp.x_result_valid = 1'b0;
        cresp.x_result.data  = $urandom;
        check("res_left_wait", 64'(creq.x_result_ready), 64'd0);
        check("res_req_ready", 64'(req_ready), 64'd1);
        tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_random(input int count);
        for (int t = 0; t < count; t++) begin
            run_txn(5'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        instr     = '0;
        rs        = '0;
        kill      = 1'b0;
        cresp     = '0;
        id_model  = ID_INIT;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_cvxif_req", 64'(|creq), 64'd0);
        check("reset_wb", 64'({wb_valid, wb_rd, wb_data}), 64'd0);
        check("reset_pulses", 64'({illegal, timeout}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // accepted path: bytes {1,2,3,4}.{1,1,1,1} = 0x0A
        run_txn(5'd5, 32'h0102_0304, 32'h0101_0101, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        // coprocessor rejects
        run_txn(5'd7, $urandom, $urandom, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        // backpressure then kill in COMMIT
        run_txn(5'd9, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 5, 0, 0, 1'b0, 1'b0);
        // accepted without writeback
        run_txn(5'd3, $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        // stale results then the matching one
        run_txn(5'd12, $urandom, $urandom, 1'b1, 1'b1, 1'b0, 2, 2, 1, 1'b0, 1'b0);
        // more than 2^X_ID_WIDTH transactions to wrap the id
        run_random(17);
        // no result arrives
        run_txn(5'd20, $urandom, $urandom, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        // reset while waiting for the result
        run_txn(5'd31, $urandom, $urandom, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        run_txn(5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        run_random(20);
        repeat (3) tick();
        check("final_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
